// File: rtl/cache_stats_reader_pkg.sv
// ============================================================================
// cache_stats_reader_pkg : shared widths, comm_o field positions, FSM states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cache_stats_reader_pkg;

  localparam int c_IDX_W       = 5;
  localparam int c_DATA_W      = 32;
  localparam int c_ENTRY_W     = c_DATA_W + c_IDX_W;
  localparam int c_COMM_EN_BIT = 24;

  typedef logic [1:0] state_t;

  localparam state_t c_S_IDLE    = 2'd0;
  localparam state_t c_S_ISSUE   = 2'd1;
  localparam state_t c_S_CAPTURE = 2'd2;
  localparam state_t c_S_DONE    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/cache_stats_reader_fifo.sv
// ============================================================================
// stats_fifo : power-of-two circular buffer holding captured {index, data}
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module stats_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_count == (c_PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/cache_stats_reader.sv
// ============================================================================
// cache_stats_reader : sweeps performance-controller comm indices and queues
//                      each returned word with its index for a consumer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cache_stats_reader
  import cache_stats_reader_pkg::*;
#(
  parameter logic [c_IDX_W-1:0] FIRST_CODE = 5'b00000,
  parameter logic [c_IDX_W-1:0] LAST_CODE  = 5'b10011,
  parameter int                 FIFO_DEPTH = 4,
  parameter bit                 FREEZE     = 1'b1
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic                start_i,
  input  logic                count_en_i,
  output logic [31:0]         comm_o,
  output logic [1:0]          select_o,
  input  logic [31:0]         comm_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         data_o,
  output logic [c_IDX_W-1:0]  index_o,
  output logic                valid_o,
  input  logic                ready_i
);

  state_t                      r_state;
  logic [c_IDX_W-1:0]          r_idx;
  logic                        w_push;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic [c_ENTRY_W-1:0]        w_head;
  logic [c_IDX_W-1:0]          w_idx_out;
  logic                        w_count_en;
  logic                        w_head_ok;

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      r_state <= c_S_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (start_i) begin
            r_idx   <= FIRST_CODE;
            r_state <= c_S_ISSUE;
          end
        end
        c_S_ISSUE:   r_state <= c_S_CAPTURE;
        // A full FIFO holds the FSM here; comm_i stays valid, so it resamples.
        c_S_CAPTURE: begin
          if (!w_fifo_full) begin
            if (r_idx == LAST_CODE) begin
              r_state <= c_S_DONE;
            end else begin
              r_idx   <= r_idx + c_IDX_W'(1);
              r_state <= c_S_ISSUE;
            end
          end
        end
        c_S_DONE:    r_state <= c_S_IDLE;
        default:     r_state <= c_S_IDLE;
      endcase
    end
  end

  assign w_push = (r_state == c_S_CAPTURE) && !w_fifo_full;

  stats_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .push_i   (w_push),
    .wdata_i  ({r_idx, comm_i}),
    .pop_i    (valid_o && ready_i),
    .rdata_o  (w_head),
    .full_o   (w_fifo_full),
    .empty_o  (w_fifo_empty),
    .count_o  (w_fifo_count)
  );

  // Outputs are gated by resetn_i so they read as idle for the whole reset.
  assign busy_o    = resetn_i && (r_state != c_S_IDLE);
  assign done_o    = resetn_i && (r_state == c_S_DONE);
  assign valid_o   = resetn_i && (w_fifo_count != '0);
  assign w_head_ok = resetn_i && !w_fifo_empty;
  assign data_o    = w_head_ok ? w_head[c_DATA_W-1:0] : '0;
  assign index_o   = w_head_ok ? w_head[c_ENTRY_W-1:c_DATA_W] : '0;
  assign select_o  = 2'b00;

  assign w_idx_out  = (resetn_i && (r_state == c_S_ISSUE || r_state == c_S_CAPTURE))
                      ? r_idx : '0;
  assign w_count_en = count_en_i && resetn_i && !(FREEZE && busy_o);

  always_comb begin
    comm_o                 = '0;
    comm_o[c_COMM_EN_BIT]  = w_count_en;
    comm_o[c_IDX_W-1:0]    = w_idx_out;
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_stats_reader.sv
// ============================================================================
// tb_cache_stats_reader : directed and randomized checks of cache_stats_reader
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cache_stats_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        start_c;
  logic        count_en;
  logic        ready;

  logic [31:0] comm_o_a, comm_o_b, comm_o_c;
  logic [31:0] comm_i_a, comm_i_b, comm_i_c;
  logic [1:0]  sel_a, sel_b, sel_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [31:0] data_a, data_b, data_c;
  logic [4:0]  index_a, index_b, index_c;
  logic        valid_a, valid_b, valid_c;

  logic [31:0] tbl [32];
  logic [36:0] qa[$], qb[$], qc[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int busy_cnt_a, busy_cnt_c, done_cnt_a, done_cnt_b, done_cnt_c;
  int done_at_a, done_at_c, pops_a;
  bit chk_comm  = 1'b0;
  bit rand_rdy  = 1'b0;

  always #5 clk = ~clk;

  cache_stats_reader u_dut_a (
    .clock_i(clk), .resetn_i(resetn), .start_i(start), .count_en_i(count_en),
    .comm_o(comm_o_a), .select_o(sel_a), .comm_i(comm_i_a), .busy_o(busy_a),
    .done_o(done_a), .data_o(data_a), .index_o(index_a), .valid_o(valid_a),
    .ready_i(ready));

  cache_stats_reader #(.FREEZE(1'b0)) u_dut_b (
    .clock_i(clk), .resetn_i(resetn), .start_i(start), .count_en_i(count_en),
    .comm_o(comm_o_b), .select_o(sel_b), .comm_i(comm_i_b), .busy_o(busy_b),
    .done_o(done_b), .data_o(data_b), .index_o(index_b), .valid_o(valid_b),
    .ready_i(ready));

  cache_stats_reader #(.FIRST_CODE(5'b01111), .LAST_CODE(5'b01111)) u_dut_c (
    .clock_i(clk), .resetn_i(resetn), .start_i(start_c), .count_en_i(count_en),
    .comm_o(comm_o_c), .select_o(sel_c), .comm_i(comm_i_c), .busy_o(busy_c),
    .done_o(done_c), .data_o(data_c), .index_o(index_c), .valid_o(valid_c),
    .ready_i(ready));

  // Controller model: registered lookup of the presented index.
  always @(posedge clk) begin
    comm_i_a <= tbl[comm_o_a[4:0]];
    comm_i_b <= tbl[comm_o_b[4:0]];
    comm_i_c <= tbl[comm_o_c[4:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_tbl(input bit ramp);
    for (int i = 0; i < 32; i++) tbl[i] = ramp ? (32'hA000_0000 + 32'(i)) : $urandom;
  endtask

  task automatic expect_sweep_ab();
    for (int i = 0; i < 20; i++) begin
      qa.push_back({5'(i), tbl[i]});
      qb.push_back({5'(i), tbl[i]});
    end
  endtask

  task automatic clear_counts();
    busy_cnt_a = 0; busy_cnt_c = 0;
    done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
    done_at_a  = -1; done_at_c = -1; pops_a = 0;
  endtask

  // One clock: sample and score at the falling edge, then step past the rise.
  task automatic cyc();
    @(negedge clk);
    if (valid_a && ready) begin
      chk("A_word_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) chk("A_word", {index_a, data_a}, qa.pop_front());
      pops_a++;
    end
    if (valid_b && ready) begin
      chk("B_word_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) chk("B_word", {index_b, data_b}, qb.pop_front());
    end
    if (valid_c && ready) begin
      chk("C_word_expected", 64'(qc.size() != 0), 64'd1);
      if (qc.size() != 0) chk("C_word", {index_c, data_c}, qc.pop_front());
    end
    if (!valid_a) chk("A_head_zero_when_empty", {index_a, data_a}, 64'd0);
    if (busy_a) busy_cnt_a++;
    if (busy_c) busy_cnt_c++;
    if (done_a) begin done_cnt_a++; done_at_a = ncyc; end
    if (done_b) done_cnt_b++;
    if (done_c) begin done_cnt_c++; done_at_c = ncyc; end
    if (chk_comm) begin
      chk("A_comm_en", comm_o_a[24], busy_a ? 1'b0 : count_en);
      chk("B_comm_en", comm_o_b[24], count_en);
      chk("A_comm_reserved", comm_o_a & ~32'h0100_001F, 64'd0);
      if (!busy_a) chk("A_comm_idx_idle", comm_o_a[4:0], 64'd0);
    end
    @(posedge clk);
    #1;
    ncyc++;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0 ||
            busy_a || busy_b || busy_c) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_within_budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    int s;
    int n;
    resetn = 1'b0; start = 1'b0; start_c = 1'b0; ready = 1'b1; count_en = 1'b1;
    fill_tbl(1'b1);
    clear_counts();
    repeat (3) cyc();

    // Reset state, with count_en_i high to show comm_o is still forced to 0.
    chk("rst_busy",   busy_a,   64'd0);
    chk("rst_done",   done_a,   64'd0);
    chk("rst_valid",  valid_a,  64'd0);
    chk("rst_head",   {index_a, data_a}, 64'd0);
    chk("rst_comm",   comm_o_a, 64'd0);
    chk("select_zero", {sel_a, sel_b, sel_c}, 64'd0);
    resetn = 1'b1;
    cyc();

    // Full sweep with ramp data, ready held high, freeze behaviour observed.
    chk_comm = 1'b1;
    clear_counts();
    expect_sweep_ab();
    start = 1'b1; s = ncyc; cyc(); start = 1'b0;
    drain(200);
    repeat (2) cyc();
    chk("S1_done_latency", done_at_a - s - 1, 64'd40);
    chk("S1_busy_cycles",  busy_cnt_a, 64'd41);
    chk("S1_done_pulses",  done_cnt_a, 64'd1);
    chk("S1_done_pulses_B", done_cnt_b, 64'd1);
    chk_comm = 1'b0;
    count_en = 1'b0;

    // Back-pressure: nothing consumed, FIFO fills and the FSM parks at index 4.
    fill_tbl(1'b0);
    clear_counts();
    ready = 1'b0;
    expect_sweep_ab();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (30) cyc();
    chk("S2_valid",      valid_a, 64'd1);
    chk("S2_busy",       busy_a,  64'd1);
    chk("S2_parked_idx", comm_o_a[4:0], 64'd4);
    chk("S2_head_idx",   index_a, 64'd0);
    chk("S2_nothing_popped", qa.size(), 64'd20);
    chk("S2_no_done",    done_cnt_a, 64'd0);
    ready = 1'b1;
    drain(200);
    chk("S2_done_pulses", done_cnt_a, 64'd1);

    // Second start mid-sweep is ignored.
    fill_tbl(1'b0);
    clear_counts();
    expect_sweep_ab();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    drain(200);
    repeat (5) cyc();
    chk("S4_done_pulses", done_cnt_a, 64'd1);
    chk("S4_busy_cycles", busy_cnt_a, 64'd41);
    chk("S4_fifo_empty",  valid_a, 64'd0);
    chk("S4_words_popped", pops_a, 64'd20);

    // Reset mid-sweep at index 7 with words 4..6 still queued.
    fill_tbl(1'b0);
    clear_counts();
    expect_sweep_ab();
    start = 1'b1; cyc(); start = 1'b0;
    n = 0;
    while (comm_o_a[4:0] != 5'd5 && n < 60) begin cyc(); n++; end
    chk("S5_reach_idx5", comm_o_a[4:0], 64'd5);
    ready = 1'b0;
    n = 0;
    while (comm_o_a[4:0] != 5'd7 && n < 60) begin cyc(); n++; end
    chk("S5_reach_idx7", comm_o_a[4:0], 64'd7);
    chk("S5_popped_before_reset", pops_a, 64'd4);
    chk("S5_head_before_reset", index_a, 64'd4);
    qa.delete(); qb.delete(); qc.delete();
    resetn = 1'b0; cyc(); resetn = 1'b1;
    chk("S5_valid_after_rst", valid_a, 64'd0);
    chk("S5_busy_after_rst",  busy_a,  64'd0);
    chk("S5_comm_after_rst",  comm_o_a, 64'd0);
    chk("S5_head_after_rst",  {index_a, data_a}, 64'd0);
    repeat (3) cyc();
    chk("S5_no_done", done_cnt_a, 64'd0);
    ready = 1'b1;
    expect_sweep_ab();
    start = 1'b1; cyc(); start = 1'b0;
    drain(200);
    chk("S5_restart_done", done_cnt_a, 64'd1);

    // Single-index sweep on the FIRST_CODE == LAST_CODE instance.
    fill_tbl(1'b0);
    clear_counts();
    qc.push_back({5'd15, tbl[15]});
    start_c = 1'b1; s = ncyc; cyc(); start_c = 1'b0;
    drain(50);
    repeat (2) cyc();
    chk("S6_done_latency", done_at_c - s - 1, 64'd2);
    chk("S6_busy_cycles",  busy_cnt_c, 64'd3);
    chk("S6_done_pulses",  done_cnt_c, 64'd1);

    // Randomized back-pressure sweeps on A and B.
    for (int k = 0; k < 3; k++) begin
      fill_tbl(1'b0);
      clear_counts();
      expect_sweep_ab();
      rand_rdy = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      drain(600);
      rand_rdy = 1'b0;
      ready = 1'b1;
      repeat (2) cyc();
      chk("R_done_pulses", done_cnt_a, 64'd1);
      chk("R_words_popped", pops_a, 64'd20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_stats_reader.md
CACHE_STATS_READER -- requirements
Module: cache_stats_reader

Interface
REQ-001 SHALL have parameter FIRST_CODE, default 5'b00000, first comm index swept.
REQ-002 SHALL have parameter LAST_CODE, default 5'b10011, last comm index swept (inclusive, >= FIRST_CODE).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >= 2).
REQ-004 SHALL have parameter FREEZE, default 1; when 1, counting is halted during a sweep.
REQ-005 clock_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn_i  input  1  synchronous, active-low reset.
REQ-007 start_i  input  1  single-cycle request to begin one sweep.
REQ-008 count_en_i  input  1  host request that performance counters run.
REQ-009 comm_o  output  32  to the performance controller's comm_i; bit 24 is the count enable, bits [4:0] are the index, all other bits are 0.
REQ-010 select_o  output  2  to the controller's select_data_record; constant 2'b00.
REQ-011 comm_i  input  32  from the controller's comm_o; registered value for the index presented.
REQ-012 busy_o  output  1  high from start acceptance until the sweep completes.
REQ-013 done_o  output  1  one-cycle pulse when the last word has been pushed.
REQ-014 data_o  output  32  FIFO head, the captured word.
REQ-015 index_o  output  5  the comm index of data_o.
REQ-016 valid_o  output  1  FIFO non-empty.
REQ-017 ready_i  input  1  consumer accepts the head when valid_o && ready_i.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, DONE.
REQ-019 In IDLE, start_i SHALL load idx=FIRST_CODE and go to ISSUE; start_i SHALL be ignored in every other state.
REQ-020 comm_o[4:0] SHALL equal idx in ISSUE and CAPTURE, and 0 in IDLE and DONE.
REQ-021 comm_o[24] SHALL be count_en_i, forced 0 while busy_o when FREEZE=1.
REQ-022 ISSUE SHALL last exactly one cycle, then go to CAPTURE; this covers the controller's one-cycle registered latency.
REQ-023 In CAPTURE with FIFO not full: push {idx, comm_i}. If idx==LAST_CODE go to DONE, else idx+1 and go to ISSUE.
REQ-024 In CAPTURE with FIFO full: no push, stay in CAPTURE, and resample each cycle. A pop in the same cycle does not free space until the next cycle.
REQ-025 DONE SHALL assert done_o for one cycle, then go to IDLE; busy_o SHALL be low in IDLE only.
REQ-026 A sweep SHALL push exactly LAST_CODE-FIRST_CODE+1 words, in ascending index order, at 2 cycles per word when never full.
REQ-027 FIFO: push and pop in the same cycle SHALL both occur. Count SHALL stay within 0..FIFO_DEPTH, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 data_o and index_o SHALL be the head entry, and 0 when empty.
REQ-029 FIFO contents left from an earlier sweep SHALL remain and drain ahead of new words.

Reset
REQ-030 While resetn_i is low: state=IDLE, idx=0, FIFO empty, busy_o=0, done_o=0, valid_o=0, data_o=0, index_o=0, comm_o=0.
REQ-031 Reset mid-sweep SHALL abort the sweep, discard all FIFO entries, and emit no done_o.

Structure
REQ-032 The shared package SHALL hold the FSM state enum, the 5-bit index width, and the comm_o bit-24 enable position.
REQ-033 The FIFO SHALL be a sub-module stats_fifo (32+5 bits wide, FIFO_DEPTH deep, push/pop/full/empty/count).

Verification
REQ-034 Scenario 1: controller model returns 32'hA000_0000+index, ready_i=1, start pulse. Required: 20 words, index 0..19, data A000_0000..A000_0013; done_o 40 cycles after start; busy_o high 41 cycles.
REQ-035 Scenario 2: ready_i=0 throughout, FIFO_DEPTH=4. Required: 4 words stored, FSM held in CAPTURE at idx 4. Then ready_i=1: the remaining 16 words arrive in order with none lost or duplicated.
REQ-036 Scenario 3: count_en_i=1, FREEZE=1. Required: comm_o[24]=0 for the whole busy_o window and 1 in IDLE. With FREEZE=0, comm_o[24]=1 throughout.
REQ-037 Scenario 4: second start_i pulse 6 cycles into a sweep. Required: ignored, exactly 20 words pushed.
REQ-038 Scenario 5: resetn_i low for 1 cycle at idx 7 with 3 words queued. Required: the next cycle shows valid_o=0, busy_o=0, comm_o=0, and no done_o. A fresh start then restarts at index 0.
REQ-039 Scenario 6: FIRST_CODE=LAST_CODE=5'b01111. Required: a single word equal to the controller ID word, with done_o 2 cycles after start.
